// File: rtl/seq_add_pkg.sv
// Shared types and constants for the nibble-serial adder.
package seq_add_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_add_ctrl_rca_4bit.sv
// Single 4-bit ripple-carry adder slice; the only arithmetic resource of seq_add_ctrl.
module rca_4bit
  import seq_add_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               c_in,
  output logic [SLICE_W-1:0] sum,
  output logic               c_out
);

  logic [SLICE_W:0] carry;

  // Explicit ripple chain, one full adder per bit.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = c_in;
    for (int i = 0; i < int'(SLICE_W); i++) begin
      sum[i]       = x[i] ^ y[i] ^ carry[i];
      carry[i + 1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end
    c_out = carry[SLICE_W];
  end

endmodule

// File: rtl/seq_add_ctrl.sv
// Nibble-serial adder: one shared 4-bit slice adds NIBBLES slices over NIBBLES cycles.
// Optional overflow output enabled by defining SEQ_ADD_OVF_EN.
module seq_add_ctrl
  import seq_add_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [SLICE_W*NIBBLES-1:0] x,
  input  logic [SLICE_W*NIBBLES-1:0] y,
  input  logic                       c_in,
  output logic                       busy,
  output logic                       done,
  output logic [SLICE_W*NIBBLES-1:0] sum,
  output logic                       c_out
`ifdef SEQ_ADD_OVF_EN
  ,
  output logic                       ovf
`endif
);

  localparam int unsigned W     = SLICE_W * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [W-1:0]       x_q, x_next;
  logic [W-1:0]       y_q, y_next;
  logic               carry_q, carry_next;
  logic [W-1:0]       sum_next;
  logic               c_out_next;
  logic               busy_next;
  logic               done_next;

  logic [SLICE_W-1:0] slice_x;
  logic [SLICE_W-1:0] slice_y;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

`ifdef SEQ_ADD_OVF_EN
  logic               ovf_next;
`endif

  assign slice_x = x_q[idx*SLICE_W +: SLICE_W];
  assign slice_y = y_q[idx*SLICE_W +: SLICE_W];

  rca_4bit u_rca (
    .x     (slice_x),
    .y     (slice_y),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_cout)
  );

  // State and datapath registers; reset clears everything including a half-done sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef SEQ_ADD_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      x_q     <= x_next;
      y_q     <= y_next;
      carry_q <= carry_next;
      sum     <= sum_next;
      c_out   <= c_out_next;
      busy    <= busy_next;
      done    <= done_next;
`ifdef SEQ_ADD_OVF_EN
      ovf     <= ovf_next;
`endif
    end
  end

  // Next-state and datapath control; busy/done are registered from the next state.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    x_next     = x_q;
    y_next     = y_q;
    carry_next = carry_q;
    sum_next   = sum;
    c_out_next = c_out;
    busy_next  = 1'b0;
    done_next  = 1'b0;
`ifdef SEQ_ADD_OVF_EN
    ovf_next   = ovf;
`endif

    unique case (state)
      IDLE: begin
        if (start) begin
          x_next     = x;
          y_next     = y;
          carry_next = c_in;
          idx_next   = '0;
          state_next = RUN;
          busy_next  = 1'b1;
        end
      end

      RUN: begin
        sum_next[idx*SLICE_W +: SLICE_W] = slice_sum;
        carry_next = slice_cout;
        if (idx == LAST_IDX) begin
          idx_next   = '0;
          c_out_next = slice_cout;
          done_next  = 1'b1;
          state_next = DONE;
`ifdef SEQ_ADD_OVF_EN
          // Top result bit comes straight from this final slice.
          ovf_next = (x_q[W-1] == y_q[W-1]) && (slice_sum[SLICE_W-1] != x_q[W-1]);
`endif
        end else begin
          idx_next  = idx + IDX_W'(1);
          busy_next = 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_add_ctrl.sv
// Directed self-checking bench for seq_add_ctrl (NIBBLES=4).
module tb_seq_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] x;
  logic [15:0] y;
  logic        c_in;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        c_out;
`ifdef SEQ_ADD_OVF_EN
  logic        ovf;
`endif

  int checks;
  int failures;

  seq_add_ctrl #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
`ifdef SEQ_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one addition and check latency, busy length, result and the hold after done.
  task automatic add_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic ci, input logic [15:0] es, input logic ec,
                           input logic eovf);
    int lat;
    int busy_n;
    @(negedge clk);
    x = a; y = b; c_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x = ~a; y = ~b;
    lat = 1;
    busy_n = 0;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd5);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd4);
    check({tag, "_busy_with_done"}, 32'(busy), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_c_out"}, 32'(c_out), 32'(ec));
`ifdef SEQ_ADD_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`else
    if (eovf === 1'bx) check({tag, "_ovf_arg"}, 32'(eovf), 32'd0);
`endif
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_sum_hold"}, 32'({c_out, sum}), 32'({ec, es}));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    x = '0;
    y = '0;
    c_in = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_c_out", 32'(c_out), 32'd0);
    rst_n = 1'b1;

    // First start lands on the first rising edge after release.
    start = 1'b1; x = 16'h0001; y = 16'h0001; c_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("first_edge_busy", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    check("first_edge_done", 32'(done), 32'd1);
    check("first_edge_sum", 32'(sum), 32'h0002);
    @(negedge clk);

    add_check("one_plus_one", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    add_check("ripple_all", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    add_check("max_max_cin", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    add_check("mixed_cin", 16'h89AB, 16'h7654, 1'b1, 16'h0000, 1'b1, 1'b0);
    add_check("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    add_check("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    add_check("no_ovf", 16'h0003, 16'hFFFF, 1'b0, 16'h0002, 1'b1, 1'b0);

    // Start held high; operand change during RUN must not leak in.
    @(negedge clk);
    x = 16'h1234; y = 16'h1111; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    check("held_busy_c1", 32'(busy), 32'd1);
    x = 16'hAAAA;
    repeat (4) @(negedge clk);
    check("held_done", 32'(done), 32'd1);
    check("held_sum", 32'(sum), 32'h2345);
    check("held_c_out", 32'(c_out), 32'd0);
    @(negedge clk);
    check("held_idle_busy", 32'(busy), 32'd0);
    check("held_idle_done", 32'(done), 32'd0);
    check("held_idle_sum", 32'(sum), 32'h2345);
    @(negedge clk);
    check("held_reaccept_busy", 32'(busy), 32'd1);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("held_second_done", 32'(done), 32'd1);
    check("held_second_sum", 32'(sum), 32'hBBBB);
    @(negedge clk);

    // Reset in the second RUN cycle discards the addition.
    x = 16'h0003; y = 16'h0004; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("midrun_busy", 32'(busy), 32'd1);
    check("midrun_partial", 32'(sum[3:0]), 32'h7);
    rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_sum", 32'(sum), 32'd0);
    check("midrun_rst_c_out", 32'(c_out), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("midrun_no_done", 32'({busy, done}), 32'd0);
    end
    add_check("after_reset", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
